// File: rtl/bus_slave_burst.sv
`default_nettype none
// ============================================================================
// Module   : bus_slave_burst
// Brief    : Bit-serial bus memory slave with wrapping multi-word bursts,
//            delayed gap-free read streaming and block-RAM storage.
// Revision : 1.0 - initial release
// ============================================================================
module bus_slave_burst #(
  parameter int MEM_KB  = 2,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 12,
  parameter int BURST_W = 3,
  parameter int DELAY   = 20
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       validIn,
  input  logic       wren,
  input  logic       Address,
  input  logic       DataIn,
  input  logic       BusAvailable,
  output logic       ready,
  output logic       validOut,
  output logic       hold,
  output logic       DataOut,
  output logic [2:0] state_out
);

  localparam int c_DEPTH = MEM_KB * 1024;
  localparam int c_AW    = $clog2(c_DEPTH);
  localparam int c_HDR_W = ADDR_W + BURST_W;
  localparam int c_HCW   = $clog2(c_HDR_W + 1);
  localparam int c_BW    = $clog2(DATA_W);
  localparam int c_LW    = BURST_W + 1;
  localparam int c_DW    = $clog2(DELAY + 1);

  localparam logic [c_HCW-1:0] c_HDR_LAST = c_HCW'(c_HDR_W - 1);
  localparam logic [c_BW-1:0]  c_BIT_LAST = c_BW'(DATA_W - 1);
  localparam logic [c_DW-1:0]  c_DELAY    = c_DW'(DELAY);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_WR     = 3'd2,
    S_RDWAIT = 3'd3,
    S_RD     = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [c_HDR_W-2:0]  r_hdr;        // header bits received so far (last bit comes from the pin)
  logic [c_HCW-1:0]    r_hdrCnt;
  logic                r_wren;
  logic [c_AW-1:0]     r_addr;       // next word to write / fetch, wraps at DEPTH
  logic [c_LW-1:0]     r_len;
  logic [c_LW-1:0]     r_wordCnt;
  logic [c_BW-1:0]     r_bitCnt;
  logic [DATA_W-1:0]   r_shift;
  logic [c_DW-1:0]     r_dlyCnt;
  logic                r_rdActive;   // 0 during the first RD cycle (initial word load)
  logic                r_ready;
  logic                r_hold;
  logic                r_validOut;
  logic                r_dataOut;
  logic [DATA_W-1:0]   r_rdData;
  logic [DATA_W-1:0]   r_mem [c_DEPTH];

  logic                w_idleStart;
  logic                w_hdrShift;
  logic                w_hdrDone;
  logic                w_wrBit;
  logic                w_wrWord;
  logic                w_rdBit;
  logic                w_rdLoad;
  logic [c_HDR_W-1:0]  w_hdrFull;
  logic [DATA_W-1:0]   w_wrData;
  logic [c_LW-1:0]     w_wordNext;

  assign w_hdrFull  = {r_hdr, Address};
  assign w_wrData   = {r_shift[DATA_W-2:0], DataIn};
  assign w_wordNext = r_wordCnt + c_LW'(1);

  assign ready     = r_ready;
  assign validOut  = r_validOut;
  assign hold      = r_hold;
  assign DataOut   = r_dataOut;
  assign state_out = r_state;

  // State register; reset returns to IDLE immediately from any state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    w_nextState = r_state;
    w_idleStart = 1'b0;
    w_hdrShift  = 1'b0;
    w_hdrDone   = 1'b0;
    w_wrBit     = 1'b0;
    w_wrWord    = 1'b0;
    w_rdBit     = 1'b0;
    w_rdLoad    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (validIn) begin
          w_idleStart = 1'b1;
          w_nextState = S_HDR;
        end
      end
      S_HDR: begin
        if (validIn) begin
          if (r_hdrCnt == c_HDR_LAST) begin
            w_hdrDone   = 1'b1;
            w_nextState = r_wren ? S_WR : S_RDWAIT;
          end else begin
            w_hdrShift = 1'b1;
          end
        end
      end
      S_WR: begin
        if (validIn) begin
          w_wrBit = 1'b1;
          if (r_bitCnt == c_BIT_LAST) begin
            w_wrWord = 1'b1;
            if (w_wordNext == r_len) w_nextState = S_IDLE;
          end
        end
      end
      S_RDWAIT: begin
        if (r_dlyCnt == c_DELAY && BusAvailable) w_nextState = S_RD;
      end
      S_RD: begin
        if (!r_rdActive) begin
          w_rdLoad = 1'b1;
        end else begin
          w_rdBit = 1'b1;
          if (r_bitCnt == c_BIT_LAST) begin
            if (r_wordCnt == r_len) w_nextState = S_IDLE;
            else                    w_rdLoad    = 1'b1;
          end
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Datapath: header capture, bit/word counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hdr      <= '0;
      r_hdrCnt   <= '0;
      r_wren     <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_wordCnt  <= '0;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_dlyCnt   <= '0;
      r_rdActive <= 1'b0;
      r_ready    <= 1'b1;
      r_hold     <= 1'b0;
      r_validOut <= 1'b0;
      r_dataOut  <= 1'b0;
    end else begin
      r_ready    <= (w_nextState == S_IDLE);
      r_hold     <= (r_state == S_RDWAIT) && (r_dlyCnt < c_DELAY);
      r_validOut <= (r_state == S_RD) && r_rdActive;
      r_dataOut  <= (r_state == S_RD) && r_rdActive && r_shift[DATA_W-1];

      if (w_idleStart) begin
        r_hdr      <= {r_hdr[c_HDR_W-3:0], Address};
        r_hdrCnt   <= c_HCW'(1);
        r_wren     <= wren;
        r_wordCnt  <= '0;
        r_bitCnt   <= '0;
        r_dlyCnt   <= '0;
        r_rdActive <= 1'b0;
      end
      if (w_hdrShift) begin
        r_hdr    <= {r_hdr[c_HDR_W-3:0], Address};
        r_hdrCnt <= r_hdrCnt + c_HCW'(1);
      end
      if (w_hdrDone) begin
        r_addr <= c_AW'(w_hdrFull >> BURST_W);
        r_len  <= c_LW'(w_hdrFull[BURST_W-1:0]) + c_LW'(1);
      end

      if (w_wrBit) begin
        r_shift  <= w_wrData;
        r_bitCnt <= w_wrWord ? '0 : r_bitCnt + c_BW'(1);
      end
      if (w_wrWord) begin
        r_addr    <= r_addr + c_AW'(1);
        r_wordCnt <= w_wordNext;
      end

      if (r_state == S_RDWAIT && r_dlyCnt != c_DELAY) r_dlyCnt <= r_dlyCnt + c_DW'(1);

      if (w_rdBit) begin
        r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
        r_bitCnt <= (r_bitCnt == c_BIT_LAST) ? '0 : r_bitCnt + c_BW'(1);
      end
      // A load on the last bit of a word overrides the shift so the stream has no gap.
      if (w_rdLoad) begin
        r_shift    <= r_rdData;
        r_addr     <= r_addr + c_AW'(1);
        r_wordCnt  <= w_wordNext;
        r_rdActive <= 1'b1;
      end
    end
  end

  // Block RAM: no reset so contents survive it; the read port tracks r_addr every
  // cycle, so r_rdData already holds the next word whenever the stream needs it.
  always_ff @(posedge clk) begin
    if (w_wrWord) r_mem[r_addr] <= w_wrData;
    r_rdData <= r_mem[r_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_slave_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_slave_burst
// Brief    : Self-checking bench for bus_slave_burst against a word-array
//            memory model and cycle-exact read timing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_slave_burst;

  localparam int MEM_KB  = 2;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 12;
  localparam int BURST_W = 3;
  localparam int DELAY   = 20;
  localparam int DEPTH   = MEM_KB * 1024;
  localparam int HDR_W   = ADDR_W + BURST_W;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       validIn = 1'b0;
  logic       wren = 1'b0;
  logic       Address = 1'b0;
  logic       DataIn = 1'b0;
  logic       BusAvailable = 1'b1;
  logic       ready;
  logic       validOut;
  logic       hold;
  logic       DataOut;
  logic [2:0] state_out;

  int compares = 0;
  int fails = 0;
  int cyc = 0;
  int bitCount = 0;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] wrData [8];

  bus_slave_burst #(
    .MEM_KB(MEM_KB), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .DELAY(DELAY)
  ) dut (
    .clk(clk), .rstn(rstn), .validIn(validIn), .wren(wren), .Address(Address),
    .DataIn(DataIn), .BusAvailable(BusAvailable), .ready(ready), .validOut(validOut),
    .hold(hold), .DataOut(DataOut), .state_out(state_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One qualified bit; optional 3-cycle validIn gap every 5 bits, with junk on the pins.
  task automatic sendBit(input logic a, input logic d, input logic w, input bit stall);
    if (stall && bitCount != 0 && (bitCount % 5) == 0) begin
      repeat (3) begin
        validIn = 1'b0;
        Address = 1'($urandom);
        DataIn  = 1'($urandom);
        tick();
        chk("stall_ready", 32'(ready), 32'd0);
      end
    end
    validIn = 1'b1;
    Address = a;
    DataIn  = d;
    wren    = w;
    tick();
    validIn = 1'b0;
    Address = 1'($urandom);
    DataIn  = 1'($urandom);
    wren    = 1'($urandom);
    bitCount++;
  endtask

  task automatic sendHeader(input int addr, input int len, input logic wr, input bit stall);
    logic [HDR_W-1:0] hdr;
    hdr = {ADDR_W'(addr), BURST_W'(len - 1)};
    bitCount = 0;
    for (int i = HDR_W - 1; i >= 0; i--) begin
      sendBit(hdr[i], 1'($urandom), (i == HDR_W - 1) ? wr : 1'($urandom), stall);
      chk("hdr_ready", 32'(ready), 32'd0);
      chk("hdr_state", 32'(state_out), (i != 0) ? 32'd1 : (wr ? 32'd2 : 32'd3));
    end
  endtask

  // Write wrData[0..len-1]; abortBits>0 stops after that many data bits.
  task automatic writeBurst(input int addr, input int len, input bit stall, input int abortBits);
    int sent;
    logic [DATA_W-1:0] wd;
    sent = 0;
    sendHeader(addr, len, 1'b1, stall);
    for (int w = 0; w < len; w++) begin
      wd = wrData[w];
      for (int b = DATA_W - 1; b >= 0; b--) begin
        if (abortBits > 0 && sent == abortBits) return;
        sendBit(1'($urandom), wd[b], 1'($urandom), stall);
        sent++;
        if (w == len - 1 && b == 0) begin
          chk("wr_end_ready", 32'(ready), 32'd1);
          chk("wr_end_state", 32'(state_out), 32'd0);
        end else begin
          chk("wr_ready", 32'(ready), 32'd0);
          chk("wr_state", 32'(state_out), 32'd2);
        end
        if (b == 0) model[((addr % DEPTH) + w) % DEPTH] = wd;
      end
    end
  endtask

  // Read and check hold window, validOut window and every bit against the model.
  // BusAvailable is held low for 'extra' cycles past the delay, random once streaming.
  task automatic readBurst(input int addr, input int len, input int extra);
    int h, v0, L, k, c, last;
    logic [DATA_W-1:0] wd;
    logic expHold, expValid, expData;
    BusAvailable = (extra == 0);
    sendHeader(addr, len, 1'b0, 1'b0);
    h    = cyc - 1;
    v0   = h + DELAY + 4 + extra;
    L    = len * DATA_W;
    last = v0 + L + 1;
    while (cyc <= last) begin
      c        = cyc;
      expHold  = (c >= h + 2) && (c <= h + DELAY + 1);
      expValid = (c >= v0) && (c < v0 + L);
      expData  = 1'b0;
      if (expValid) begin
        k       = c - v0;
        wd      = model[((addr % DEPTH) + k / DATA_W) % DEPTH];
        expData = wd[DATA_W - 1 - (k % DATA_W)];
      end
      chk("rd_hold", 32'(hold), 32'(expHold));
      chk("rd_validOut", 32'(validOut), 32'(expValid));
      chk("rd_DataOut", 32'(DataOut), 32'(expData));
      if (expHold) chk("rd_ready", 32'(ready), 32'd0);
      if (c >= h + 2 + DELAY + extra) BusAvailable = 1'($urandom);
      else                            BusAvailable = (c >= h + 1 + DELAY + extra);
      tick();
    end
    BusAvailable = 1'b1;
    chk("rd_end_ready", 32'(ready), 32'd1);
    chk("rd_end_state", 32'(state_out), 32'd0);
  endtask

  initial begin
    int a, n, ex;
    bit st;

    // Reset state while held in reset, then one cycle after release.
    repeat (3) tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_validOut", 32'(validOut), 32'd0);
    chk("rst_hold", 32'(hold), 32'd0);
    chk("rst_DataOut", 32'(DataOut), 32'd0);
    chk("rst_state", 32'(state_out), 32'd0);
    rstn = 1'b1;
    tick();
    chk("rel_ready", 32'(ready), 32'd1);
    chk("rel_state", 32'(state_out), 32'd0);

    // Single write then read with default parameters.
    wrData[0] = 8'hA5;
    writeBurst(12'h005, 1, 1'b0, 0);
    readBurst(12'h005, 1, 0);
    // Address bits above the memory depth are ignored.
    readBurst(12'h805, 1, 0);

    // Wrapping burst across DEPTH-1 -> 0.
    wrData[0] = 8'h11; wrData[1] = 8'h22; wrData[2] = 8'h33; wrData[3] = 8'h44;
    writeBurst(12'h7FE, 4, 1'b0, 0);
    readBurst(12'h7FE, 4, 0);
    readBurst(12'h000, 2, 0);

    // Bus contention: 10 extra cycles after the delay expires.
    readBurst(12'h7FE, 4, 10);

    // Write with validIn gaps in header and data.
    a = int'($urandom_range(0, 4095));
    for (int i = 0; i < 5; i++) wrData[i] = DATA_W'($urandom);
    writeBurst(a, 5, 1'b1, 0);
    readBurst(a, 5, 0);

    // Reset after 1.5 words of a 3-word write; old contents pre-loaded first.
    a = 12'h3F0;
    for (int i = 0; i < 3; i++) wrData[i] = DATA_W'($urandom);
    writeBurst(a, 3, 1'b0, 0);
    for (int i = 0; i < 3; i++) wrData[i] = ~wrData[i];
    writeBurst(a, 3, 1'b0, 12);
    #2 rstn = 1'b0;
    #1;
    chk("arst_state", 32'(state_out), 32'd0);
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_hold", 32'(hold), 32'd0);
    chk("arst_validOut", 32'(validOut), 32'd0);
    chk("arst_DataOut", 32'(DataOut), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    chk("arst_rel_ready", 32'(ready), 32'd1);
    readBurst(a, 3, 0);

    // Randomised write/read pairs.
    for (int t = 0; t < 6; t++) begin
      a  = int'($urandom_range(0, 4095));
      n  = int'($urandom_range(1, 8));
      st = 1'($urandom);
      ex = int'($urandom_range(0, 4));
      for (int i = 0; i < n; i++) wrData[i] = DATA_W'($urandom);
      writeBurst(a, n, st, 0);
      readBurst(a, n, ex);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_slave_burst.md
# bus_slave_burst

Serial-bus memory slave with parametrised data width, memory depth, read latency and burst length. It sits on the same serial bus as the existing single-word slave and uses the same bit-serial header and data framing. It adds multi-word bursts with auto-incrementing, wrapping addresses, continuous read streaming and an asynchronous active-low reset. Memory is inferred block RAM, one word per address.

## Interface

Parameters:
- MEM_KB, 2, memory depth in Kwords; DEPTH = MEM_KB*1024; must be a power of two.
- DATA_W, 8, word width in bits; at least 2.
- ADDR_W, 12, serial address field width; at least clog2(DEPTH).
- BURST_W, 3, burst-length field width; a burst is LEN = field+1 words (1..2^BURST_W).
- DELAY, 20, read-access wait in cycles; at least 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  reset; asynchronous assert, active-low.
- validIn  in  1  master qualifies Address/DataIn this cycle.
- wren  in  1  1 = write burst, 0 = read burst; sampled only with the first header bit.
- Address  in  1  serial header: ADDR_W address bits, then BURST_W length bits, MSB first.
- DataIn  in  1  serial write data, MSB first.
- BusAvailable  in  1  bus granted for read return.
- ready  out  1  slave idle and able to accept a header.
- validOut  out  1  DataOut carries a read bit.
- hold  out  1  read access in progress; bus may be released.
- DataOut  out  1  serial read data, MSB first.
- state_out  out  3  current FSM state.

## Operation

- States and encodings: IDLE=0, HDR=1, WR=2, RDWAIT=3, RD=4. Unused encodings go to IDLE.
- IDLE
  - ready=1.
  - On validIn=1, capture the first header bit, latch wren, set bit count to 1, go to HDR.
- HDR
  - Each validIn=1 cycle shifts in one Address bit; validIn=0 stalls without losing state.
  - After ADDR_W+BURST_W bits: addr = address mod DEPTH and LEN = field+1.
  - Then go to WR if the latched wren=1, otherwise to RDWAIT.
- WR
  - Each validIn=1 cycle shifts in one DataIn bit.
  - On the DATA_W-th bit: write mem[addr] with the full word including that bit, set addr = (addr+1) mod DEPTH, increment the word count, clear the bit count.
  - After LEN words, go to IDLE.
- RDWAIT
  - hold=1 while the delay counter < DELAY; the counter increments every cycle.
  - Once the counter reaches DELAY: hold=0, and go to RD when BusAvailable=1, otherwise stay.
- RD
  - First cycle: load the shift register from mem[addr]; addr increments.
  - Following cycles: drive one bit per cycle, MSB first.
  - When a word's last bit is driven, load the next word in the same cycle, so the stream has no gaps.
  - After LEN*DATA_W bits, go to IDLE.
  - BusAvailable is ignored once in RD.
- Addresses wrap at DEPTH: DEPTH-1 is followed by 0. Address bits above clog2(DEPTH) are ignored.
- Memory is never cleared by reset; contents survive reset.

## Timing

- Reset values: ready=1, validOut=0, hold=0, DataOut=0, state_out=0. All counters and shift registers are zero.
- Reset is asynchronous and may assert in any state, including mid-burst. The FSM returns to IDLE immediately.
  - A partially received write word is discarded.
  - Words already committed stay written.
- All outputs are registered.
- ready
  - Falls in the cycle after the first header bit is sampled.
  - Rises in the cycle after the FSM returns to IDLE.
- Write timing: a word is visible to a later read from the cycle after its last bit is sampled.
- Read timing: the last header bit is sampled at cycle h.
  - hold=1 over cycles h+2 .. h+DELAY+1.
  - With BusAvailable=1, validOut rises at cycle h+DELAY+4.
  - validOut then stays high for exactly LEN*DATA_W consecutive cycles, and DataOut=0 when validOut=0.
  - Each cycle BusAvailable is low after the delay expires adds one cycle.
- A validIn gap of any length in HDR or WR only stalls the transfer. There is no timeout.
- A new header is accepted only while ready=1.

## Test plan

- Reset then idle: assert rstn low mid-cycle -> all outputs are at reset values immediately; ready=1 one cycle after release.
- Single write then read, defaults: write 0xA5 to 0x005 with LEN=1, then read 0x005 -> validOut high for 8 cycles; DataOut=1,0,1,0,0,1,0,1; hold high for 20 cycles.
- Wrapping burst: write LEN=4 at 0x7FE with data 0x11,0x22,0x33,0x44, then read LEN=4 at 0x7FE -> words return in order; 0x33/0x44 reside at 0x000/0x001; validOut is one unbroken 32-cycle pulse.
- Bus contention: read with BusAvailable held low 10 cycles beyond DELAY -> hold falls after 20 cycles; validOut rises exactly 10 cycles later than the uncontended case.
- Stalls: write burst with validIn dropped 3 cycles every 5 bits in header and data -> memory matches a write without stalls; ready stays 0 throughout.
- Reset mid-burst: assert rstn after 1.5 words of a LEN=3 write -> the first word is committed, the second address is unchanged, state_out=0, and the next header is accepted normally.
